keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad, synchronizes and debounces the column inputs, and presents one clean 4-bit key code per physical press. It sits directly upstream of the keyboard cache, which shifts in every non-idle code.
- Idle code is 4'b1111.
- Each press therefore produces exactly one transition from 4'b1111 to a key code, and back to 4'b1111 on release.

---
 rtl/keypad_scanner.sv | 144 ++++++++++++++
 tb/tb_keypad_scanner.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one row per scan tick,
// synchronizes the column inputs, debounces press and release, and presents
// one clean 4-bit key code per physical press (4'b1111 when idle).
module keypad_scanner #(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CNT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_data,
  output logic       key_valid
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_DONE  = DB_W'(DEBOUNCE_CNT);
  localparam logic [3:0]       IDLE     = 4'b1111;

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } state_t;

  state_t           state;
  logic [3:0]       col_meta;
  logic [3:0]       col_s;
  logic [DIV_W-1:0] div;
  logic             tick;
  logic [DB_W-1:0]  db_cnt;
  logic [1:0]       row;
  logic [3:0]       cand_code;
  logic [3:0]       cand_cols;
  logic             one_low;
  logic [1:0]       low_idx;
  logic [3:0]       scan_code;
  logic             press_ok;

  // Two-flop synchronizer for the asynchronous, pulled-up column lines.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep both flops sampling the pre-edge values.
    if (rst) begin
      col_meta <= IDLE;
      col_s    <= IDLE;
    end else begin
      col_meta <= col_in;
      col_s    <= col_meta;
    end
  end

  // Free-running scan divider; tick marks the last cycle of each scan period.
  always_ff @(posedge clk) begin
    if (rst)       div <= '0;
    else if (tick) div <= '0;
    else           div <= div + 1'b1;
  end

  assign tick = (div == DIV_LAST);

  // Decode the sampled columns: exactly one low column gives a candidate key.
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    one_low = 1'b0;
    low_idx = 2'd0;
    case (col_s)
      4'b1110: begin one_low = 1'b1; low_idx = 2'd0; end
      4'b1101: begin one_low = 1'b1; low_idx = 2'd1; end
      4'b1011: begin one_low = 1'b1; low_idx = 2'd2; end
      4'b0111: begin one_low = 1'b1; low_idx = 2'd3; end
      default: ;
    endcase
  end

  // Row 3 / column 3 encodes as the idle code, so it can never be a key.
  assign scan_code = {row, low_idx};
  assign press_ok  = one_low && (scan_code != IDLE);
  assign row_out   = ~(4'b0001 << row);

  // Scan / debounce FSM with registered key outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      row       <= 2'd0;
      db_cnt    <= '0;
      cand_code <= IDLE;
      cand_cols <= IDLE;
      key_data  <= IDLE;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (tick) begin
            if (press_ok) begin
              cand_code <= scan_code;
              cand_cols <= col_s;
              db_cnt    <= '0;
              state     <= PRESS_DB;
            end else begin
              row <= row + 2'd1;
            end
          end
        end
        PRESS_DB: begin
          if (db_cnt == DB_DONE) begin
            key_data  <= cand_code;
            key_valid <= 1'b1;
            state     <= HELD;
          end else if (tick) begin
            if (col_s == cand_cols) begin
              db_cnt <= db_cnt + 1'b1;
            end else begin
              row   <= row + 2'd1;
              state <= SCAN;
            end
          end
        end
        HELD: begin
          // Extra keys while held are ignored; only a fully idle sample counts.
          if (tick && (col_s == IDLE)) begin
            db_cnt <= '0;
            state  <= RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (db_cnt == DB_DONE) begin
            key_data <= IDLE;
            row      <= row + 2'd1;
            state    <= SCAN;
          end else if (tick) begin
            if (col_s == IDLE) db_cnt <= db_cnt + 1'b1;
            else               state  <= HELD;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a behavioural 4x4 keypad (set of pressed keys
// wired through the driven row) and compares the DUT every cycle against a
// reference model built from the press/release debounce rules.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_in = 4'hF;
  logic [3:0] row_out;
  logic [3:0] key_data;
  logic       key_valid;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_data  (key_data),
    .key_valid (key_valid)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Physical keypad: bit k set means key {row,col}=k is held down.
  logic [15:0] pressed = '0;

  // Reference model: cycle position in the scan period, scanned row, expected
  // outputs, candidate key (-1 none), held flag, and debounce streak (-1 none).
  int         m_div, m_row, m_key, m_cand, m_streak;
  bit         m_valid, m_held;
  logic [3:0] m_sync1, m_col_s;

  int         pulses;
  logic [3:0] last_code;
  logic [3:0] rows_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] keypad_cols(input logic [3:0] rows, input logic [15:0] keys);
    logic [3:0] c;
    c = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!rows[r])
        for (int k = 0; k < 4; k++)
          if (keys[r*4+k]) c[k] = 1'b0;
    return c;
  endfunction

  function automatic logic [3:0] one_cold(input int idx);
    logic [3:0] v;
    v = 4'hF;
    v[idx] = 1'b0;
    return v;
  endfunction

  // Advance the model by one rising edge using the pre-edge inputs.
  task automatic model_step();
    logic [3:0] pat;
    bit         tk;
    int         zeros, col, code;
    pat = m_col_s;
    tk  = (m_div == SCAN_DIV - 1);
    if (rst) begin
      m_div = 0; m_row = 0; m_key = 15; m_valid = 0;
      m_cand = -1; m_held = 0; m_streak = -1;
      m_sync1 = 4'hF; m_col_s = 4'hF;
      return;
    end
    zeros = 0; col = 0;
    for (int c = 0; c < 4; c++) if (!pat[c]) begin zeros++; col = c; end
    code = m_row * 4 + col;
    m_valid = 0;
    if (!m_held) begin
      if (m_cand < 0) begin
        if (tk) begin
          if (zeros == 1 && code != 15) begin m_cand = code; m_streak = 0; end
          else m_row = (m_row + 1) % 4;
        end
      end else if (m_streak == DEB) begin
        m_held = 1; m_key = m_cand; m_valid = 1; m_streak = -1;
      end else if (tk) begin
        if (pat == one_cold(m_cand % 4)) m_streak++;
        else begin m_cand = -1; m_streak = -1; m_row = (m_row + 1) % 4; end
      end
    end else begin
      if (m_streak < 0) begin
        if (tk && pat == 4'hF) m_streak = 0;
      end else if (m_streak == DEB) begin
        m_key = 15; m_row = (m_row + 1) % 4; m_held = 0; m_cand = -1; m_streak = -1;
      end else if (tk) begin
        if (pat == 4'hF) m_streak++;
        else m_streak = -1;
      end
    end
    m_col_s = m_sync1;
    m_sync1 = col_in;
    m_div   = (m_div + 1) % SCAN_DIV;
  endtask

  // One clock: drive columns at negedge, step model at posedge, compare at +1.
  task automatic cycle();
    @(negedge clk);
    col_in = keypad_cols(row_out, pressed);
    @(posedge clk);
    model_step();
    #1;
    check("row_out", 32'(row_out), 32'(one_cold(m_row)));
    check("key_data", 32'(key_data), m_key);
    check("key_valid", 32'(key_valid), 32'(m_valid));
    if (key_valid === 1'b1) begin
      pulses++;
      last_code = key_data;
    end
    for (int r = 0; r < 4; r++) if (row_out[r] === 1'b0) rows_seen[r] = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_valid(input string tag, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      cycle();
      if (key_valid === 1'b1) seen = 1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    int k, hold, gap, nb;

    pulses = 0; last_code = 4'hF; rows_seen = '0;
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    check("rst_row", 32'(row_out), 32'h E);
    check("rst_key", 32'(key_data), 32'h F);
    check("rst_valid", 32'(key_valid), 32'd0);

    // Clean press of key 2 (row 0, column 2).
    pulses = 0; pressed = '0; pressed[2] = 1'b1;
    run(40);
    check("clean_pulses", pulses, 1);
    check("clean_code", 32'(last_code), 32'h2);
    check("clean_held", 32'(key_data), 32'h2);
    pressed = '0;
    run(30);
    check("clean_release", 32'(key_data), 32'hF);
    check("clean_no_rel_pulse", pulses, 1);

    // Row 2, column 0.
    pulses = 0; pressed[8] = 1'b1;
    wait_valid("row2_accept", 60);
    check("row2_code", 32'(last_code), 32'h8);
    run(10);
    check("row2_frozen", 32'(row_out), 32'hB);
    check("row2_pulses", pulses, 1);
    pressed = '0;
    run(30);

    // Bounce on key 1 (row 0, column 1), one tick on / one tick off.
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      pressed[1] = ~pressed[1];
      run(SCAN_DIV);
    end
    check("bounce_pulses", pulses, 0);
    check("bounce_key", 32'(key_data), 32'hF);
    pressed[1] = 1'b1;
    run(40);
    check("bounce_stable_pulses", pulses, 1);
    check("bounce_stable_code", 32'(last_code), 32'h1);
    pressed = '0;
    run(30);

    // Release glitch while holding key 5.
    pulses = 0; pressed[5] = 1'b1;
    wait_valid("glitch_accept", 60);
    check("glitch_code", 32'(key_data), 32'h5);
    pressed[5] = 1'b0;
    run(SCAN_DIV);
    pressed[5] = 1'b1;
    run(24);
    check("glitch_held", 32'(key_data), 32'h5);
    check("glitch_pulses", pulses, 1);
    pressed = '0;
    run(30);

    // Key F alone, then two columns low in row 1.
    pulses = 0; rows_seen = '0; pressed[15] = 1'b1;
    run(40);
    check("keyf_pulses", pulses, 0);
    check("keyf_key", 32'(key_data), 32'hF);
    check("keyf_rows", 32'(rows_seen), 32'hF);
    pressed = '0; rows_seen = '0; pressed[4] = 1'b1; pressed[5] = 1'b1;
    run(40);
    check("multi_pulses", pulses, 0);
    check("multi_key", 32'(key_data), 32'hF);
    check("multi_rows", 32'(rows_seen), 32'hF);
    pressed = '0;
    run(20);

    // Reset while holding key 3; key stays down and is re-accepted.
    pressed[3] = 1'b1;
    wait_valid("rsthold_accept", 60);
    check("rsthold_code", 32'(key_data), 32'h3);
    run(5);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rsthold_row", 32'(row_out), 32'hE);
    check("rsthold_key", 32'(key_data), 32'hF);
    check("rsthold_valid", 32'(key_valid), 32'd0);
    pulses = 0;
    wait_valid("rsthold_reaccept", 60);
    check("rsthold_recode", 32'(last_code), 32'h3);
    run(10);
    check("rsthold_pulses", pulses, 1);
    pressed = '0;
    run(30);

    // Randomized presses with bounce, extra keys and occasional reset.
    for (int it = 0; it < 30; it++) begin
      k = $urandom_range(0, 15);
      pressed = '0;
      nb = $urandom_range(0, 3);
      for (int b = 0; b < nb; b++) begin
        pressed[k] = ~pressed[k];
        run($urandom_range(1, 6));
      end
      pressed[k] = 1'b1;
      if ($urandom_range(0, 3) == 0) pressed[$urandom_range(0, 15)] = 1'b1;
      hold = $urandom_range(8, 60);
      run(hold);
      if ($urandom_range(0, 7) == 0) begin
        rst = 1'b1;
        cycle();
        rst = 1'b0;
      end
      run($urandom_range(0, 10));
      pressed = '0;
      gap = $urandom_range(5, 40);
      run(gap);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
